// File: rtl/mem_request_queue.sv
// mem_request_queue: FIFO request buffer between the trace parser and the
// DRAM command scheduler. It stores opcode and address per request and
// tracks a saturating per-entry residency age.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid            parser presents a request this cycle
//   in_opcode           0=READ 1=WRITE 2=IFETCH 3=reserved (rejected)
//   in_address          request address
//   op_ready_s          not-full; flow control back to the parser
//   out_valid           head entry present
//   out_opcode          head opcode (0 when empty)
//   out_address         head address (0 when empty)
//   out_age             head residency age in clocks (0 when empty)
//   out_ready           scheduler consumes the head this cycle
//   count               occupied entries
//   drop_err            one-cycle pulse after a reserved opcode is rejected
module mem_request_queue #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH   = 16,
  parameter int unsigned AGE_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [1:0]                   in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]     in_address,
  output logic                         op_ready_s,
  output logic                         out_valid,
  output logic [1:0]                   out_opcode,
  output logic [ADDRESS_WIDTH-1:0]     out_address,
  output logic [AGE_WIDTH-1:0]         out_age,
  input  logic                         out_ready,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                         drop_err
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     drop_q, drop_d;
  logic [1:0]               opcode_q [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_q   [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]     age_q    [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]     age_d    [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]   occ_c;
  logic                     push_c, pop_c;

  // Flow control and head presentation; empty queue drives zeros.
  always_comb begin
    op_ready_s  = (count_q != CNT_W'(QUEUE_DEPTH));
    out_valid   = (count_q != '0);
    out_opcode  = out_valid ? opcode_q[head_q] : 2'd0;
    out_address = out_valid ? addr_q[head_q] : '0;
    out_age     = out_valid ? age_q[head_q] : '0;
    count       = count_q;
    drop_err    = drop_q;
  end

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      occ_c[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
    end
  end

  // Next-state: pointers, count, drop pulse and ages.
  always_comb begin
    push_c  = in_valid && op_ready_s && (in_opcode != OP_RESERVED);
    pop_c   = out_valid && out_ready;
    drop_d  = in_valid && op_ready_s && (in_opcode == OP_RESERVED);
    head_d  = pop_c  ? PTR_W'(head_q + PTR_W'(1)) : head_q;
    tail_d  = push_c ? PTR_W'(tail_q + PTR_W'(1)) : tail_q;
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
      2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
      default: count_d = count_q;
    endcase
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      age_d[i] = age_q[i];
      // The written slot is never occupied: a push only happens when not full.
      if (push_c && (PTR_W'(i) == tail_q)) begin
        age_d[i] = '0;
      end else if (occ_c[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = AGE_WIDTH'(age_q[i] + AGE_WIDTH'(1));
      end
    end
  end

  // State registers with synchronous reset clearing all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        opcode_q[i] <= 2'd0;
        addr_q[i]   <= '0;
        age_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      age_q   <= age_d;
      if (push_c) begin
        opcode_q[tail_q] <= in_opcode;
        addr_q[tail_q]   <= in_address;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
module tb_mem_request_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_opcode;
  logic [31:0] in_address;
  logic        op_ready_s;
  logic        out_valid;
  logic [1:0]  out_opcode;
  logic [31:0] out_address;
  logic [7:0]  out_age;
  logic        out_ready;
  logic [4:0]  count;
  logic        drop_err;

  int checks;
  int failures;

  mem_request_queue #(
    .ADDRESS_WIDTH(32),
    .QUEUE_DEPTH  (16),
    .AGE_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_address (in_address),
    .op_ready_s (op_ready_s),
    .out_valid  (out_valid),
    .out_opcode (out_opcode),
    .out_address(out_address),
    .out_age    (out_age),
    .out_ready  (out_ready),
    .count      (count),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_opcode = 2'd1; in_address = 32'h0000_0055; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (count !== 5'd0 || out_valid !== 1'b0 || op_ready_s !== 1'b1 || drop_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got count=%0d valid=%b ready=%b drop=%b exp 0 0 1 0",
                 k, count, out_valid, op_ready_s, drop_err);
      end
    end
    checks++;
    if (out_opcode !== 2'd0 || out_address !== 32'd0 || out_age !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got op=%0d addr=%h age=%0d exp 0 0 0", out_opcode, out_address, out_age);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_nothing_stored got count=%0d valid=%b exp 0 0", count, out_valid);
    end
  endtask

  task automatic test_single_age();
    in_valid = 1'b1; in_opcode = 2'd0; in_address = 32'h0000_1A40;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_opcode !== 2'd0 || out_address !== 32'h0000_1A40 || count !== 5'd1) begin
      failures++;
      $display("FAIL single_head got valid=%b op=%0d addr=%h count=%0d exp 1 0 00001a40 1",
               out_valid, out_opcode, out_address, count);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_age !== 8'(k)) begin
        failures++;
        $display("FAIL single_age got=%0d exp=%0d", out_age, k);
      end
      if (k < 9) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || out_address !== 32'd0 || out_age !== 8'd0) begin
      failures++;
      $display("FAIL single_pop got count=%0d valid=%b addr=%h age=%0d exp 0 0 0 0",
               count, out_valid, out_address, out_age);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_opcode = 2'(i % 3); in_address = 32'(i * 32'h100);
      step();
    end
    checks++;
    if (count !== 5'd16 || op_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got count=%0d ready=%b exp 16 0", count, op_ready_s);
    end
    in_opcode = 2'd1; in_address = 32'h0000_0BAD;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd16) begin
      failures++;
      $display("FAIL fill_17th_rejected got count=%0d exp 16", count);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_address !== 32'(i * 32'h100) || out_opcode !== 2'(i % 3)) begin
        failures++;
        $display("FAIL drain_order idx=%0d got valid=%b addr=%h op=%0d exp 1 %h %0d",
                 i, out_valid, out_address, out_opcode, i * 32'h100, i % 3);
      end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || op_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty got count=%0d valid=%b ready=%b exp 0 0 1", count, out_valid, op_ready_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_opcode = 2'd1; in_address = 32'h2000 + 32'(i * 4);
      exp_q.push_back(in_address);
      step();
    end
    checks++;
    if (count !== 5'd8 || out_address !== 32'h2000) begin
      failures++;
      $display("FAIL b2b_setup got count=%0d addr=%h exp 8 00002000", count, out_address);
    end
    in_opcode = 2'd2; in_address = 32'h3000; out_ready = 1'b1;
    exp_q.push_back(in_address);
    void'(exp_q.pop_front());
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd8 || out_address !== 32'h2004) begin
      failures++;
      $display("FAIL b2b_mid got count=%0d addr=%h exp 8 00002004", count, out_address);
    end
    for (int i = 0; i < 8; i++) begin
      in_opcode = 2'd0; in_address = 32'h4000 + 32'(i * 4);
      exp_q.push_back(in_address);
      step();
    end
    checks++;
    if (count !== 5'd16 || op_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full got count=%0d ready=%b exp 16 0", count, op_ready_s);
    end
    // Full: the push is refused even though a pop frees a slot.
    in_address = 32'h5000; out_ready = 1'b1;
    void'(exp_q.pop_front());
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== 5'd15 || op_ready_s !== 1'b1 || out_address !== 32'h2008) begin
      failures++;
      $display("FAIL b2b_full_pop got count=%0d ready=%b addr=%h exp 15 1 00002008",
               count, op_ready_s, out_address);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_address !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_drain idx=%0d got valid=%b addr=%h exp 1 %h", i, out_valid, out_address, exp_q[i]);
      end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got count=%0d valid=%b exp 0 0", count, out_valid);
    end
  endtask

  task automatic test_reserved();
    in_valid = 1'b1; in_opcode = 2'd3; in_address = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0; in_opcode = 2'd0;
    checks++;
    if (drop_err !== 1'b1 || count !== 5'd0 || out_valid !== 1'b0 || out_address !== 32'd0) begin
      failures++;
      $display("FAIL reserved_pulse got drop=%b count=%0d valid=%b addr=%h exp 1 0 0 0",
               drop_err, count, out_valid, out_address);
    end
    step();
    checks++;
    if (drop_err !== 1'b0 || count !== 5'd0 || out_address === 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL reserved_after got drop=%b count=%0d addr=%h exp 0 0 0", drop_err, count, out_address);
    end
  endtask

  task automatic test_age_sat_reset();
    in_valid = 1'b1; in_opcode = 2'd2; in_address = 32'h0000_7000;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 254) begin
        checks++;
        if (out_age !== 8'd254) begin
          failures++;
          $display("FAIL age_254 got=%0d exp=254", out_age);
        end
      end
    end
    checks++;
    if (out_age !== 8'd255 || out_address !== 32'h0000_7000) begin
      failures++;
      $display("FAIL age_saturate got age=%0d addr=%h exp 255 00007000", out_age, out_address);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_opcode = 2'd0; in_address = 32'h8000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd5) begin
      failures++;
      $display("FAIL preset_count got=%0d exp=5", count);
    end
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || out_age !== 8'd0 || op_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL midreset got count=%0d valid=%b age=%0d ready=%b exp 0 0 0 1",
               count, out_valid, out_age, op_ready_s);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after got count=%0d valid=%b exp 0 0", count, out_valid);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 2'd0; in_address = 32'd0; out_ready = 1'b0;
    test_reset();
    test_single_age();
    test_fill_drain();
    test_back_to_back();
    test_reserved();
    test_age_sat_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
